// File: rtl/evg_tx_scheduler_if.sv
// EVG transmit scheduler bus: event push, dbus, segment request, SFP lane.
// Master drives requests; slave (the scheduler) drives the lane and status.
interface evg_tx_scheduler_if #(
    parameter int SEG_BYTES = 16
);
    logic                   enable;
    logic [7:0]             ev_code;
    logic                   ev_valid;
    logic                   ev_ready;
    logic [7:0]             dbus;
    logic                   seg_start;
    logic [7:0]             seg_addr;
    logic [8*SEG_BYTES-1:0] seg_data;
    logic                   seg_busy;
    logic                   seg_done;
    logic [15:0]            tx_data;
    logic [1:0]             txcharisk;

    modport master (
        output enable, ev_code, ev_valid, dbus,
        output seg_start, seg_addr, seg_data,
        input  ev_ready, seg_busy, seg_done, tx_data, txcharisk
    );

    modport slave (
        input  enable, ev_code, ev_valid, dbus,
        input  seg_start, seg_addr, seg_data,
        output ev_ready, seg_busy, seg_done, tx_data, txcharisk
    );
endinterface

// File: rtl/evg_tx_scheduler.sv
// EVG SFP transmit scheduler: commas and queued events on the upper byte,
// distributed bus interleaved with segment frames on the lower byte.
module evg_tx_scheduler #(
    parameter int COMMA_PERIOD  = 4,
    parameter int SEG_BYTES     = 16,
    parameter int EV_FIFO_DEPTH = 8
) (
    input logic               tx_clk_i,
    input logic               reset_i,
    evg_tx_scheduler_if.slave bus
);
    localparam int CW   = (COMMA_PERIOD > 2) ? $clog2(COMMA_PERIOD) : 1;
    localparam int PW   = (EV_FIFO_DEPTH > 2) ? $clog2(EV_FIFO_DEPTH) : 1;
    localparam int NW   = PW + 1;
    localparam int BW   = (SEG_BYTES > 2) ? $clog2(SEG_BYTES) : 1;
    localparam int DW   = 8 * SEG_BYTES;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_ADDR, S_DATA, S_STOP, S_CKS_HI, S_CKS_LO
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           phase_q, phase_d;
    logic [PW-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [NW-1:0]  count_q, count_d;
    logic [7:0]     mem_q [EV_FIFO_DEPTH];
    logic [BW-1:0]  byte_q, byte_d;
    logic [7:0]     addr_q, addr_d;
    logic [DW-1:0]  data_q, data_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           ready_q, ready_d;
    logic [15:0]    tx_q, tx_d;
    logic [1:0]     k_q, k_d;
    logic           push, pop, accept;
    logic [15:0]    sum, cks;

    assign bus.ev_ready  = ready_q;
    assign bus.seg_busy  = busy_q;
    assign bus.seg_done  = done_q;
    assign bus.tx_data   = tx_q;
    assign bus.txcharisk = k_q;

    // Frame checksum over the latched address and payload.
    always_comb begin
        sum = {8'h00, addr_q};
        for (int i = 0; i < SEG_BYTES; i++) begin
            sum = sum + {8'h00, data_q[i*8 +: 8]};
        end
        cks = 16'hFFFF - sum;
    end

    // Slot decision: event lane, FIFO, data lane and segment FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        byte_d  = byte_q;
        addr_d  = addr_q;
        data_d  = data_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ready_d = 1'b0;
        tx_d    = 16'h0000;
        k_d     = 2'b00;
        push    = 1'b0;
        pop     = 1'b0;
        accept  = 1'b0;
        if (!bus.enable) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            phase_d = 1'b0;
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
            byte_d  = '0;
            busy_d  = 1'b0;
        end else begin
            cnt_d = (cnt_q == CW'(COMMA_PERIOD - 1)) ? '0 : cnt_q + 1'b1;
            if (cnt_q == '0) begin
                tx_d[15:8] = 8'hBC;
                k_d[1]     = 1'b1;
            end else if (count_q != '0) begin
                tx_d[15:8] = mem_q[rd_q];
                pop        = 1'b1;
            end
            push    = bus.ev_valid && ready_q;
            wr_d    = wr_q + PW'(push);
            rd_d    = rd_q + PW'(pop);
            count_d = count_q + NW'(push) - NW'(pop);
            ready_d = (count_d != NW'(EV_FIFO_DEPTH));
            phase_d = ~phase_q;
            if (done_q) busy_d = 1'b0;
            if (!phase_q) begin
                tx_d[7:0] = bus.dbus;
            end else begin
                unique case (state_q)
                    S_IDLE: tx_d[7:0] = 8'h00;
                    S_START: begin
                        tx_d[7:0] = 8'h5C;
                        k_d[0]    = 1'b1;
                        state_d   = S_ADDR;
                    end
                    S_ADDR: begin
                        tx_d[7:0] = addr_q;
                        byte_d    = '0;
                        state_d   = S_DATA;
                    end
                    S_DATA: begin
                        tx_d[7:0] = data_q[{byte_q, 3'b000} +: 8];
                        byte_d    = byte_q + 1'b1;
                        if (byte_q == BW'(SEG_BYTES - 1)) state_d = S_STOP;
                    end
                    S_STOP: begin
                        tx_d[7:0] = 8'h3C;
                        k_d[0]    = 1'b1;
                        state_d   = S_CKS_HI;
                    end
                    S_CKS_HI: begin
                        tx_d[7:0] = cks[15:8];
                        state_d   = S_CKS_LO;
                    end
                    S_CKS_LO: begin
                        tx_d[7:0] = cks[7:0];
                        done_d    = 1'b1;
                        state_d   = S_IDLE;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
            accept = bus.seg_start && (state_q == S_IDLE) && !busy_q;
            if (accept) begin
                addr_d  = bus.seg_addr;
                data_d  = bus.seg_data;
                busy_d  = 1'b1;
                state_d = S_START;
            end
        end
    end

    // Event FIFO storage; contents are don't-care while empty.
    always_ff @(posedge tx_clk_i) begin
        if (push) mem_q[wr_q] <= bus.ev_code;
    end

    // State and registered outputs.
    always_ff @(posedge tx_clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            byte_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
            tx_q    <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            byte_q  <= byte_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            tx_q    <= tx_d;
            k_q     <= k_d;
        end
    end
endmodule

// File: tb/tb_evg_tx_scheduler.sv
// Bench for evg_tx_scheduler: directed scenarios plus random traffic,
// all compared against a queue-based model of the transmit lane.
module tb_evg_tx_scheduler;
    localparam int CP  = 4;
    localparam int SB  = 16;
    localparam int DEP = 8;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    evg_tx_scheduler_if #(.SEG_BYTES(SB)) bus ();

    evg_tx_scheduler #(
        .COMMA_PERIOD(CP), .SEG_BYTES(SB), .EV_FIFO_DEPTH(DEP)
    ) dut (
        .tx_clk_i(clk),
        .reset_i (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: slot index since enable, event queue, pending frame bytes.
    int          ks;
    logic [7:0]  evq[$];
    logic [8:0]  segq[$];
    logic [15:0] m_tx;
    logic [1:0]  m_k;
    logic        m_rdy, m_busy, m_done;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic build_frame();
        int s;
        logic [15:0] c;
        s = int'(bus.seg_addr);
        segq.push_back({1'b1, 8'h5C});
        segq.push_back({1'b0, bus.seg_addr});
        for (int i = 0; i < SB; i++) begin
            segq.push_back({1'b0, bus.seg_data[i*8 +: 8]});
            s += int'(bus.seg_data[i*8 +: 8]);
        end
        c = 16'(65535 - s);
        segq.push_back({1'b1, 8'h3C});
        segq.push_back({1'b0, c[15:8]});
        segq.push_back({1'b0, c[7:0]});
    endtask

    task automatic model_edge();
        logic [15:0] ntx;
        logic [1:0]  nk;
        logic        nrdy, nbusy, ndone;
        logic [8:0]  w;
        ntx = '0; nk = '0; nrdy = 0; nbusy = 0; ndone = 0;
        if (rst || !bus.enable) begin
            ks = 0;
            evq.delete();
            segq.delete();
        end else begin
            if (ks % CP == 0) begin
                ntx[15:8] = 8'hBC;
                nk[1] = 1'b1;
            end else if (evq.size() > 0) begin
                ntx[15:8] = evq.pop_front();
            end
            if (bus.ev_valid && m_rdy) evq.push_back(bus.ev_code);
            nbusy = m_busy;
            if (ks % 2 == 0) begin
                ntx[7:0] = bus.dbus;
            end else if (segq.size() > 0) begin
                w = segq.pop_front();
                ntx[7:0] = w[7:0];
                nk[0] = w[8];
                if (segq.size() == 0) ndone = 1'b1;
            end
            if (m_done) nbusy = 1'b0;
            if (bus.seg_start && !m_busy && segq.size() == 0) begin
                build_frame();
                nbusy = 1'b1;
            end
            nrdy = (evq.size() < DEP);
            ks++;
        end
        m_tx = ntx; m_k = nk; m_rdy = nrdy; m_busy = nbusy; m_done = ndone;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        chk("tx_data", 32'(bus.tx_data), 32'(m_tx));
        chk("txcharisk", 32'(bus.txcharisk), 32'(m_k));
        chk("ev_ready", 32'(bus.ev_ready), 32'(m_rdy));
        chk("seg_busy", 32'(bus.seg_busy), 32'(m_busy));
        chk("seg_done", 32'(bus.seg_done), 32'(m_done));
    endtask

    logic [7:0] vec [SB];
    int n, dones;

    initial begin
        checks = 0; errors = 0; ks = 0;
        m_tx = '0; m_k = '0; m_rdy = 0; m_busy = 0; m_done = 0;
        vec = '{8'h00, 8'h8B, 8'hFC, 8'h7B, 8'h00, 8'h00, 8'h00, 8'h07,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h07};
        rst = 1; bus.enable = 0; bus.ev_code = 0; bus.ev_valid = 0;
        bus.dbus = 0; bus.seg_start = 0; bus.seg_addr = 0; bus.seg_data = '0;

        // Reset state
        repeat (3) step();
        chk("rst_tx", 32'(bus.tx_data), 32'h0);
        chk("rst_rdy", 32'(bus.ev_ready), 32'h0);
        rst = 0;
        step();

        // Idle link pattern
        bus.enable = 1;
        for (int r = 0; r < 2; r++) begin
            step();
            chk("idle_comma", 32'(bus.tx_data), 32'hBC00);
            chk("idle_k", 32'(bus.txcharisk), 32'h2);
            for (int j = 0; j < 3; j++) begin
                step();
                chk("idle_tx", 32'(bus.tx_data), 32'h0);
                chk("idle_k0", 32'(bus.txcharisk), 32'h0);
            end
        end

        // Four events right after the comma slot
        for (int i = 1; i <= 4; i++) begin
            bus.ev_valid = 1; bus.ev_code = 8'(i);
            step();
            chk("ev_rdy_hold", 32'(bus.ev_ready), 32'h1);
            if (i > 1) chk("ev_order", 32'(bus.tx_data[15:8]), 32'(i - 1));
        end
        bus.ev_valid = 0;
        step();
        chk("ev_comma", 32'(bus.tx_data[15:8]), 32'hBC);
        step();
        chk("ev_fourth", 32'(bus.tx_data[15:8]), 32'h04);
        repeat (4) step();

        // Continuous pushes until the FIFO saturates
        bus.ev_valid = 1;
        for (int i = 0; i < 48; i++) begin
            bus.ev_code = 8'($urandom);
            step();
        end
        bus.ev_valid = 0;
        repeat (40) step();

        // Reference segment frame, second request mid-frame
        bus.dbus = 8'h11;
        if (ks % 2 != 0) step();
        bus.seg_start = 1; bus.seg_addr = 8'hFF;
        for (int i = 0; i < SB; i++) bus.seg_data[i*8 +: 8] = vec[i];
        step();
        bus.seg_start = 0;
        n = 0; dones = 0;
        while (n < 100) begin
            bus.seg_start = (n == 10);
            bus.dbus = 8'($urandom);
            step();
            n++;
            if (bus.seg_done) begin
                dones++;
                chk("cks_lo", 32'(bus.tx_data[7:0]), 32'hF0);
            end
            if (!bus.seg_busy) break;
        end
        bus.seg_start = 0;
        chk("busy_len", 32'(n), 32'd42);
        chk("done_cnt", 32'(dones), 32'd1);

        // Disable mid-frame with events queued
        if (ks % 2 != 0) step();
        bus.seg_start = 1; bus.seg_addr = 8'h5A;
        bus.seg_data = {$urandom, $urandom, $urandom, $urandom};
        step();
        bus.seg_start = 0;
        bus.ev_valid = 1;
        for (int i = 0; i < 6; i++) begin
            bus.ev_code = 8'(8'h40 + i);
            step();
        end
        bus.ev_valid = 0;
        bus.enable = 0;
        step();
        chk("dis_tx", 32'(bus.tx_data), 32'h0);
        chk("dis_busy", 32'(bus.seg_busy), 32'h0);
        step();
        bus.enable = 1; bus.dbus = 8'hA5;
        step();
        chk("reen_tx", 32'(bus.tx_data), 32'hBCA5);
        chk("reen_k", 32'(bus.txcharisk), 32'h2);
        step();
        chk("no_stale", 32'(bus.tx_data), 32'h0);
        chk("fsm_idle", 32'(bus.seg_busy), 32'h0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 499) == 0);
            bus.enable = ($urandom_range(0, 149) != 0);
            bus.ev_valid = $urandom_range(0, 1);
            bus.ev_code = 8'($urandom);
            bus.dbus = 8'($urandom);
            bus.seg_start = ($urandom_range(0, 19) == 0);
            bus.seg_addr = 8'($urandom);
            bus.seg_data = {$urandom, $urandom, $urandom, $urandom};
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
